// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
package pipe_pkg;

    // Control bundle layout, bit 7 down to bit 0.
    localparam int CTRL_W        = 8;
    localparam int CTRL_REGDST   = 7;
    localparam int CTRL_ALUSRC   = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_ALUOP1   = 1;
    localparam int CTRL_ALUOP0   = 0;

    // Default payload and counter widths.
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_REG_AW = 5;
    localparam int PIPE_CNT_W  = 16;

    // Occupancy of the two payload slots.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // One decoded instruction as it travels from ID to EX.
    typedef struct packed {
        logic [CTRL_W-1:0]      ctrl;
        logic [PIPE_DATA_W-1:0] rdata1;
        logic [PIPE_DATA_W-1:0] rdata2;
        logic [PIPE_DATA_W-1:0] imm;
        logic [PIPE_REG_AW-1:0] rs;
        logic [PIPE_REG_AW-1:0] rt;
        logic [PIPE_REG_AW-1:0] rd;
    } payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload slot: loads a full instruction, or clears only its control
// bundle so a squashed entry turns into a bubble while data stays put.
module pipe_slot #(
    parameter int DATA_W = pipe_pkg::PIPE_DATA_W,
    parameter int REG_AW = pipe_pkg::PIPE_REG_AW,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clr_ctrl,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_rdata1,
    input  logic [DATA_W-1:0] i_rdata2,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rt,
    input  logic [REG_AW-1:0] i_rd,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    output logic [DATA_W-1:0] o_imm,
    output logic [REG_AW-1:0] o_rs,
    output logic [REG_AW-1:0] o_rt,
    output logic [REG_AW-1:0] o_rd
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;

    // Slot storage: reset clears all, clear-ctrl beats load.
    // NOTE: non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ctrl   <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
        end else if (i_clr_ctrl) begin
            r_ctrl <= '0;
        end else if (i_load) begin
            r_ctrl   <= i_ctrl;
            r_rdata1 <= i_rdata1;
            r_rdata2 <= i_rdata2;
            r_imm    <= i_imm;
            r_rs     <= i_rs;
            r_rt     <= i_rt;
            r_rd     <= i_rd;
        end
    end

    assign o_ctrl   = r_ctrl;
    assign o_rdata1 = r_rdata1;
    assign o_rdata2 = r_rdata2;
    assign o_imm    = r_imm;
    assign o_rs     = r_rs;
    assign o_rt     = r_rt;
    assign o_rd     = r_rd;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with registered valid/ready handshake, a two-entry
// skid buffer, flush-to-bubble and a saturating stall-cycle counter.
module id_ex_pipe_reg #(
    parameter int DATA_W = pipe_pkg::PIPE_DATA_W,
    parameter int REG_AW = pipe_pkg::PIPE_REG_AW,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = pipe_pkg::PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    import pipe_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_accept;
    logic              w_issue;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_main_from_skid;

    logic [CTRL_W-1:0] w_main_ctrl,   w_skid_ctrl,   w_main_in_ctrl;
    logic [DATA_W-1:0] w_main_rdata1, w_skid_rdata1, w_main_in_rdata1;
    logic [DATA_W-1:0] w_main_rdata2, w_skid_rdata2, w_main_in_rdata2;
    logic [DATA_W-1:0] w_main_imm,    w_skid_imm,    w_main_in_imm;
    logic [REG_AW-1:0] w_main_rs,     w_skid_rs,     w_main_in_rs;
    logic [REG_AW-1:0] w_main_rt,     w_skid_rt,     w_main_in_rt;
    logic [REG_AW-1:0] w_main_rd,     w_skid_rd,     w_main_in_rd;

    assign w_accept = in_valid & r_in_ready & ~flush;
    assign w_issue  = r_out_valid & out_ready;

    // Main only refills from skid when draining TWO; no accept happens there.
    assign w_main_from_skid = (r_state == TWO);
    assign w_main_in_ctrl   = w_main_from_skid ? w_skid_ctrl   : id_ctrl;
    assign w_main_in_rdata1 = w_main_from_skid ? w_skid_rdata1 : id_rdata1;
    assign w_main_in_rdata2 = w_main_from_skid ? w_skid_rdata2 : id_rdata2;
    assign w_main_in_imm    = w_main_from_skid ? w_skid_imm    : id_imm;
    assign w_main_in_rs     = w_main_from_skid ? w_skid_rs     : id_rs;
    assign w_main_in_rt     = w_main_from_skid ? w_skid_rt     : id_rt;
    assign w_main_in_rd     = w_main_from_skid ? w_skid_rd     : id_rd;

    // Next-state and slot load decode; flush squashes everything.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        if (!flush) begin
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ONE;
                        w_load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && !w_issue) begin
                        w_state_nxt = TWO;
                        w_load_skid = 1'b1;
                    end else if (w_accept && w_issue) begin
                        w_load_main = 1'b1;
                    end else if (w_issue) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (w_issue) begin
                        w_state_nxt = ONE;
                        w_load_main = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end else begin
            w_state_nxt = EMPTY;
        end
    end

    // State plus registered handshake flags, derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != TWO);
            r_out_valid <= (w_state_nxt != EMPTY);
        end
    end

    // Count cycles where execute holds off a valid instruction; saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) u_main (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load_main),
        .i_clr_ctrl (flush),
        .i_ctrl     (w_main_in_ctrl),
        .i_rdata1   (w_main_in_rdata1),
        .i_rdata2   (w_main_in_rdata2),
        .i_imm      (w_main_in_imm),
        .i_rs       (w_main_in_rs),
        .i_rt       (w_main_in_rt),
        .i_rd       (w_main_in_rd),
        .o_ctrl     (w_main_ctrl),
        .o_rdata1   (w_main_rdata1),
        .o_rdata2   (w_main_rdata2),
        .o_imm      (w_main_imm),
        .o_rs       (w_main_rs),
        .o_rt       (w_main_rt),
        .o_rd       (w_main_rd)
    );

    pipe_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load_skid),
        .i_clr_ctrl (flush),
        .i_ctrl     (id_ctrl),
        .i_rdata1   (id_rdata1),
        .i_rdata2   (id_rdata2),
        .i_imm      (id_imm),
        .i_rs       (id_rs),
        .i_rt       (id_rt),
        .i_rd       (id_rd),
        .o_ctrl     (w_skid_ctrl),
        .o_rdata1   (w_skid_rdata1),
        .o_rdata2   (w_skid_rdata2),
        .o_imm      (w_skid_imm),
        .o_rs       (w_skid_rs),
        .o_rt       (w_skid_rt),
        .o_rd       (w_skid_rd)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign ex_ctrl   = r_out_valid ? w_main_ctrl : '0;
    assign ex_rdata1 = w_main_rdata1;
    assign ex_rdata2 = w_main_rdata2;
    assign ex_imm    = w_main_imm;
    assign ex_rs     = w_main_rs;
    assign ex_rt     = w_main_rt;
    assign ex_rd     = w_main_rd;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline register with a valid/ready handshake, a two-entry skid buffer, flush-to-bubble and a stall-cycle counter. It sits between decode and execute and replaces the fixed-width, always-load ID/EX latch. It lets execute back-pressure decode without a combinational ready path, and lets hazard or branch logic squash in-flight instructions.

## Interface
- DATA_W, 32, width of operand and immediate fields
- REG_AW, 5, register-address width
- CTRL_W, 8, control-bundle width; bit order 7..0 = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp1, ALUOp0}
- CNT_W, 16, stall-counter width
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-low reset (sampled on posedge clk)
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  register can accept; registered output
- flush  in  1  squash every held instruction this edge
- id_ctrl  in  CTRL_W  decode control bundle
- id_rdata1, id_rdata2  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_AW  source and destination register numbers
- out_valid  out  1  execute-side instruction valid
- out_ready  in  1  execute consumes the instruction
- ex_ctrl  out  CTRL_W  control bundle, forced to 0 whenever out_valid=0
- ex_rdata1, ex_rdata2, ex_imm  out  DATA_W  held payload
- ex_rs, ex_rt, ex_rd  out  REG_AW  held register numbers
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- accept = in_valid & in_ready & ~flush; issue = out_valid & out_ready.
- Two payload slots: main (drives the ex_* outputs) and skid.
- States: EMPTY (no entry), ONE (main valid), TWO (main and skid valid).
- out_valid = (state != EMPTY). Next-cycle in_ready = (next state != TWO).
- EMPTY: accept -> ONE, main <= input. Otherwise stay in EMPTY.
- ONE:
  - accept & ~issue -> TWO, skid <= input.
  - accept & issue -> ONE, main <= input.
  - ~accept & issue -> EMPTY.
  - Neither -> hold.
- TWO: in_ready=0, so no accept is possible. issue -> ONE, main <= skid. Otherwise hold.
- Order is strictly FIFO. No instruction is dropped or duplicated except by flush.
- flush (when rst=1): state -> EMPTY, ctrl of both slots cleared to 0, data fields unchanged, in_ready -> 1. The input presented in the flush cycle is discarded. An issue in the flush cycle still counts as consumed by execute.
- stall_cnt increments when out_valid & ~out_ready and saturates at 2^CNT_W-1. Only reset clears it; flush does not.
- rst=0 (reset) at an edge: state EMPTY; all slot fields 0; stall_cnt 0; in_ready 1. Outputs after that edge: out_valid 0, ex_* 0. Reset overrides flush and all handshake activity, including mid-transfer.

## Timing
- Latency: instruction accepted at edge N appears on ex_* with out_valid=1 after edge N (usable in cycle N+1).
- Throughput: 1 instruction/cycle while out_ready=1.
- in_ready and out_valid are flop outputs. No combinational path from out_ready to in_ready.
- in_ready drops the cycle after the skid slot fills. Decode must hold its inputs while in_ready=0.
- ex_ctrl gating is combinational from the state flop only, with no input-to-output path.

## Structure
- Shared package pipe_pkg holds:
  - CTRL_W and named bit indices (CTRL_REGDST .. CTRL_ALUOP0)
  - the state type {EMPTY, ONE, TWO}
  - a packed payload struct parametrised by DATA_W/REG_AW
- One sub-module, pipe_slot: payload register with load enable and clear-ctrl input, instantiated twice (main, skid).
- The FSM, handshake and counter live in the top module.

## Test plan
- Reset, then stream: release rst, out_ready=1, drive 4 back-to-back instructions with id_imm=1..4 -> ex_imm 1,2,3,4 on consecutive cycles, in_ready stays 1, stall_cnt=0.
- Back-pressure: with main holding imm=5, hold out_ready=0 and present imm=6 then imm=7 -> imm=6 goes to skid, in_ready=0 next cycle, imm=7 held off. Raise out_ready -> outputs 5,6,7 in order; stall_cnt equals the cycles out_ready was 0.
- Flush in TWO: fill both slots (ctrl=8'hFF), assert flush with in_valid=1, imm=9 -> next cycle out_valid=0, ex_ctrl=0, in_ready=1, imm=9 never appears.
- Simultaneous accept+issue in ONE: main imm=3, out_ready=1, in imm=4 -> next cycle ex_imm=4, state ONE, no skid use.
- Reset mid-operation: state TWO, stall_cnt=20, drive rst=0 for one edge -> out_valid=0, all ex_*=0, stall_cnt=0, in_ready=1.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.
